// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings and widths for the pipeline stall controller and its helpers.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR      = 32'b0;
  localparam int          DIV_CYCLES_MAX = 64;
  localparam int          DIV_CNT_W      = $clog2(DIV_CYCLES_MAX);
  localparam int          LW_RUN_W       = 2;

  // The start cycle and the div_cnt==0 cycle both freeze, hence the -2.
  function automatic logic [DIV_CNT_W-1:0] div_load(input int cycles);
    return DIV_CNT_W'(cycles - 2);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_stall_sat_counter.sv
// Up-counter with synchronous clear and enable that holds at all-ones.
module stall_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Turns hazard/flush/MDU events into per-stage enables, flushes and bubbles,
// and owns the divide-wait FSM, load-stall watchdog and stall counter.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES   = 32,
  parameter int MAX_LW_STALL = 2,
  parameter int DELAY_SLOT   = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lw_conf,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             mdu_is_div,
  input  logic             exc_flush,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idexe_we,
  output logic             idexe_flush,
  output logic             exemem_bubble,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic             lw_stall_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [LW_RUN_W-1:0]  LW_MAX    = LW_RUN_W'(MAX_LW_STALL);
  localparam logic [DIV_CNT_W-1:0] DIV_START = div_load(DIV_CYCLES);

  state_e                state_q, state_d;
  logic [DIV_CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic                  lw_stall_err_q, lw_stall_err_d;
  logic [LW_RUN_W-1:0]   lw_run;
  logic                  lw_stall;

  always_comb begin
    state_d        = state_q;
    div_cnt_d      = div_cnt_q;
    lw_stall_err_d = lw_stall_err_q;
    lw_stall       = 1'b0;
    pc_we          = 1'b1;
    ifid_we        = 1'b1;
    idexe_we       = 1'b1;
    ifid_flush     = 1'b0;
    idexe_flush    = 1'b0;
    exemem_bubble  = 1'b0;
    mdu_done       = 1'b0;
    mdu_busy       = (state_q == DIV_WAIT);

    if (rst) begin
      mdu_busy = 1'b0;
    end else if (exc_flush) begin
      ifid_flush    = 1'b1;
      idexe_flush   = 1'b1;
      exemem_bubble = 1'b1;
      state_d       = FLUSH;
      div_cnt_d     = '0;
    end else if ((state_q == DIV_WAIT) || ((state_q == RUN) && mdu_start && mdu_is_div)) begin
      pc_we         = 1'b0;
      ifid_we       = 1'b0;
      idexe_we      = 1'b0;
      exemem_bubble = 1'b1;
      if (state_q == RUN) begin
        div_cnt_d = DIV_START;
        state_d   = DIV_WAIT;
      end else if (div_cnt_q == '0) begin
        mdu_done = 1'b1;
        state_d  = RUN;
      end else begin
        div_cnt_d = div_cnt_q - 1'b1;
      end
    end else if (state_q != RUN) begin
      // FLUSH is a single quiet cycle; hazards are re-evaluated once back in RUN.
      state_d = RUN;
    end else if (lw_conf) begin
      lw_stall    = 1'b1;
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idexe_flush = 1'b1;
      if (lw_run >= LW_MAX) begin
        lw_stall_err_d = 1'b1;
      end
    end else if (branch_taken && (DELAY_SLOT == 0)) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      div_cnt_q      <= '0;
      lw_stall_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_cnt_q      <= div_cnt_d;
      lw_stall_err_q <= lw_stall_err_d;
    end
  end

  assign lw_stall_err = lw_stall_err_q;

  // Frozen cycles with lw_conf high neither count nor clear the run.
  stall_sat_counter #(.W(LW_RUN_W)) u_lw_run (
    .clk (clk),
    .rst (rst),
    .clr (~lw_conf),
    .en  (lw_stall),
    .cnt (lw_run)
  );

  stall_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (~pc_we),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: a default instance and a no-delay-slot, 4-bit-counter instance.
module tb_pipe_stall_ctrl;

  typedef struct packed {
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idexe_we;
    logic        idexe_flush;
    logic        exemem_bubble;
    logic        mdu_busy;
    logic        mdu_done;
    logic        lw_err;
    logic [31:0] cnt;
  } obs_t;

  logic clk, rst, lw_conf, branch_taken, mdu_start, mdu_is_div, exc_flush;
  logic pc_we_a, ifid_we_a, ifid_flush_a, idexe_we_a, idexe_flush_a, exemem_bubble_a;
  logic mdu_busy_a, mdu_done_a, lw_err_a;
  logic [31:0] cnt_a;
  logic pc_we_b, ifid_we_b, ifid_flush_b, idexe_we_b, idexe_flush_b, exemem_bubble_b;
  logic mdu_busy_b, mdu_done_b, lw_err_b;
  logic [3:0] cnt_b;

  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] exp_cnt = 0;
  logic [3:0]  exp_cnt_b = 0;
  logic        exp_err = 0;
  obs_t sb_a[$];
  obs_t sb_b[$];

  pipe_stall_ctrl #(.DIV_CYCLES(32), .MAX_LW_STALL(2), .DELAY_SLOT(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .lw_conf(lw_conf), .branch_taken(branch_taken),
    .mdu_start(mdu_start), .mdu_is_div(mdu_is_div), .exc_flush(exc_flush),
    .pc_we(pc_we_a), .ifid_we(ifid_we_a), .ifid_flush(ifid_flush_a),
    .idexe_we(idexe_we_a), .idexe_flush(idexe_flush_a), .exemem_bubble(exemem_bubble_a),
    .mdu_busy(mdu_busy_a), .mdu_done(mdu_done_a), .lw_stall_err(lw_err_a), .stall_cnt(cnt_a)
  );

  pipe_stall_ctrl #(.DIV_CYCLES(32), .MAX_LW_STALL(2), .DELAY_SLOT(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .lw_conf(lw_conf), .branch_taken(branch_taken),
    .mdu_start(mdu_start), .mdu_is_div(mdu_is_div), .exc_flush(exc_flush),
    .pc_we(pc_we_b), .ifid_we(ifid_we_b), .ifid_flush(ifid_flush_b),
    .idexe_we(idexe_we_b), .idexe_flush(idexe_flush_b), .exemem_bubble(exemem_bubble_b),
    .mdu_busy(mdu_busy_b), .mdu_done(mdu_done_b), .lw_stall_err(lw_err_b), .stall_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t obs_a();
    obs_t o;
    o = {pc_we_a, ifid_we_a, ifid_flush_a, idexe_we_a, idexe_flush_a, exemem_bubble_a,
         mdu_busy_a, mdu_done_a, lw_err_a, cnt_a};
    return o;
  endfunction

  function automatic obs_t obs_b();
    obs_t o;
    o = {pc_we_b, ifid_we_b, ifid_flush_b, idexe_we_b, idexe_flush_b, exemem_bubble_b,
         mdu_busy_b, mdu_done_b, lw_err_b, 28'd0, cnt_b};
    return o;
  endfunction

  function automatic obs_t exp_nom();
    obs_t e;
    e = '0;
    e.pc_we = 1'b1; e.ifid_we = 1'b1; e.idexe_we = 1'b1;
    e.lw_err = exp_err;
    e.cnt = exp_cnt;
    return e;
  endfunction

  function automatic obs_t exp_lw();
    obs_t e;
    e = exp_nom();
    e.pc_we = 1'b0; e.ifid_we = 1'b0; e.idexe_flush = 1'b1;
    return e;
  endfunction

  function automatic obs_t exp_freeze(input logic busy, input logic done);
    obs_t e;
    e = exp_nom();
    e.pc_we = 1'b0; e.ifid_we = 1'b0; e.idexe_we = 1'b0; e.exemem_bubble = 1'b1;
    e.mdu_busy = busy; e.mdu_done = done;
    return e;
  endfunction

  function automatic obs_t exp_exc(input logic busy);
    obs_t e;
    e = exp_nom();
    e.ifid_flush = 1'b1; e.idexe_flush = 1'b1; e.exemem_bubble = 1'b1; e.mdu_busy = busy;
    return e;
  endfunction

  function automatic obs_t to_b(input obs_t ea);
    obs_t e;
    e = ea;
    e.cnt = {28'd0, exp_cnt_b};
    return e;
  endfunction

  task automatic apply(input logic r, input logic l, input logic b, input logic ms,
                       input logic md, input logic ex);
    rst = r; lw_conf = l; branch_taken = b; mdu_start = ms; mdu_is_div = md; exc_flush = ex;
  endtask

  // Model bookkeeping for the registered counter, then move to the next cycle.
  task automatic advance(input obs_t ea, input logic in_rst);
    if (in_rst) begin
      exp_cnt = 0; exp_cnt_b = 0;
    end else if (!ea.pc_we) begin
      exp_cnt = exp_cnt + 1;
      if (exp_cnt_b != 4'hF) exp_cnt_b = exp_cnt_b + 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    exp_cnt = 0; exp_cnt_b = 0; exp_err = 0;
    apply(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    obs_t ea, eb, oa, ob;
    for (int k = 1; k <= 3; k++) begin
      apply(1, 1, 1, 1, 1, 1);
      ea = exp_nom(); eb = to_b(ea);
      sb_a.push_back(ea); sb_b.push_back(eb);
      @(negedge clk);
      oa = obs_a(); ob = obs_b(); ea = sb_a.pop_front(); eb = sb_b.pop_front();
      n_chk += 2;
      if (oa !== ea) begin n_fail++; $display("FAIL reset[%0d] dut_a got=%h exp=%h", k, oa, ea); end
      if (ob !== eb) begin n_fail++; $display("FAIL reset[%0d] dut_b got=%h exp=%h", k, ob, eb); end
      advance(ea, 1'b1);
    end
    apply(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_use();
    obs_t ea, eb, oa, ob;
    logic l;
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      l = (k <= 3) || (k == 7);
      apply(0, l, 0, 0, 0, 0);
      exp_err = (k >= 4);
      ea = l ? exp_lw() : exp_nom(); eb = to_b(ea);
      sb_a.push_back(ea); sb_b.push_back(eb);
      @(negedge clk);
      oa = obs_a(); ob = obs_b(); ea = sb_a.pop_front(); eb = sb_b.pop_front();
      n_chk += 2;
      if (oa !== ea) begin n_fail++; $display("FAIL load_use[%0d] dut_a got=%h exp=%h", k, oa, ea); end
      if (ob !== eb) begin n_fail++; $display("FAIL load_use[%0d] dut_b got=%h exp=%h", k, ob, eb); end
      advance(ea, 1'b0);
    end
  endtask

  task automatic test_divide();
    obs_t ea, eb, oa, ob;
    do_reset();
    for (int k = 1; k <= 34; k++) begin
      if (k == 1) apply(0, 0, 0, 1, 1, 0);
      else if (k <= 32) apply(0, (k % 5) == 0, (k % 2) == 1, (k % 3) == 0, 1, 0);
      else apply(0, 0, 0, 0, 0, 0);
      ea = (k <= 32) ? exp_freeze(k >= 2, k == 32) : exp_nom(); eb = to_b(ea);
      sb_a.push_back(ea); sb_b.push_back(eb);
      @(negedge clk);
      oa = obs_a(); ob = obs_b(); ea = sb_a.pop_front(); eb = sb_b.pop_front();
      n_chk += 2;
      if (oa !== ea) begin n_fail++; $display("FAIL divide[%0d] dut_a got=%h exp=%h", k, oa, ea); end
      if (ob !== eb) begin n_fail++; $display("FAIL divide[%0d] dut_b got=%h exp=%h", k, ob, eb); end
      advance(ea, 1'b0);
    end
  endtask

  task automatic test_exc_mid_divide();
    obs_t ea, eb, oa, ob;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      if (k == 1) begin
        apply(0, 0, 0, 1, 1, 0); ea = exp_freeze(1'b0, 1'b0);
      end else if (k <= 9) begin
        apply(0, 0, 0, 0, 0, 0); ea = exp_freeze(1'b1, 1'b0);
      end else if (k == 10) begin
        apply(0, 0, 1, 1, 1, 1); ea = exp_exc(1'b1);
      end else if (k == 11 || k == 14) begin
        apply(0, 1, 0, 0, 0, 0); ea = exp_nom();
      end else if (k == 13) begin
        apply(0, 1, 0, 0, 0, 1); ea = exp_exc(1'b0);
      end else begin
        apply(0, 0, 0, 0, 0, 0); ea = exp_nom();
      end
      eb = to_b(ea);
      sb_a.push_back(ea); sb_b.push_back(eb);
      @(negedge clk);
      oa = obs_a(); ob = obs_b(); ea = sb_a.pop_front(); eb = sb_b.pop_front();
      n_chk += 2;
      if (oa !== ea) begin n_fail++; $display("FAIL exc_mid_div[%0d] dut_a got=%h exp=%h", k, oa, ea); end
      if (ob !== eb) begin n_fail++; $display("FAIL exc_mid_div[%0d] dut_b got=%h exp=%h", k, ob, eb); end
      advance(ea, 1'b0);
    end
  endtask

  task automatic test_branch_vs_stall();
    obs_t ea, eb, oa, ob;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      case (k)
        1:       begin apply(0, 1, 1, 0, 0, 0); ea = exp_lw();  eb = to_b(ea); end
        2:       begin apply(0, 0, 1, 0, 0, 0); ea = exp_nom(); eb = to_b(ea); eb.ifid_flush = 1'b1; end
        3:       begin apply(0, 0, 0, 1, 0, 0); ea = exp_nom(); eb = to_b(ea); end
        4:       begin apply(0, 0, 1, 1, 0, 0); ea = exp_nom(); eb = to_b(ea); eb.ifid_flush = 1'b1; end
        default: begin apply(0, 0, 0, 0, 0, 0); ea = exp_nom(); eb = to_b(ea); end
      endcase
      sb_a.push_back(ea); sb_b.push_back(eb);
      @(negedge clk);
      oa = obs_a(); ob = obs_b(); ea = sb_a.pop_front(); eb = sb_b.pop_front();
      n_chk += 2;
      if (oa !== ea) begin n_fail++; $display("FAIL branch_stall[%0d] dut_a got=%h exp=%h", k, oa, ea); end
      if (ob !== eb) begin n_fail++; $display("FAIL branch_stall[%0d] dut_b got=%h exp=%h", k, ob, eb); end
      advance(ea, 1'b0);
    end
  endtask

  task automatic test_saturation();
    obs_t ea, eb, oa, ob;
    do_reset();
    for (int k = 1; k <= 21; k++) begin
      exp_err = (k >= 4);
      if (k <= 20) begin
        apply(0, 1, 0, 0, 0, 0); ea = exp_lw();
      end else begin
        apply(0, 0, 0, 1, 0, 0); ea = exp_nom();
      end
      eb = to_b(ea);
      sb_a.push_back(ea); sb_b.push_back(eb);
      @(negedge clk);
      oa = obs_a(); ob = obs_b(); ea = sb_a.pop_front(); eb = sb_b.pop_front();
      n_chk += 2;
      if (oa !== ea) begin n_fail++; $display("FAIL saturation[%0d] dut_a got=%h exp=%h", k, oa, ea); end
      if (ob !== eb) begin n_fail++; $display("FAIL saturation[%0d] dut_b got=%h exp=%h", k, ob, eb); end
      advance(ea, 1'b0);
    end
  endtask

  initial begin
    apply(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_divide();
    test_exc_mid_divide();
    test_branch_vs_stall();
    test_saturation();
    n_chk++;
    if (sb_a.size() + sb_b.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb_a.size() + sb_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
